// File: rtl/nl_fc_pkg.sv
// Shared types, constants and helpers for output-port credit flow control.
// The optional credit-error checking is enabled by the macro NL_FC_CREDIT_CHECK_EN.
package nl_fc_pkg;

  // ceil(log2(n)), never less than 1, so that it can size a bus.
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int FC_NUM_VCS        = 2;
  localparam int FC_MAX_CREDIT_RET = 2;
  // Wide enough to carry out-of-range indices, which the receiver ignores.
  localparam int FC_VC_IDX_BITS    = 3;
  localparam int FC_RET_BITS       = clogb2(FC_MAX_CREDIT_RET + 1);

  typedef logic [FC_VC_IDX_BITS-1:0] vc_index_t;

  typedef struct packed {
    logic [FC_NUM_VCS-1:0] vc_id;
  } flit_ctrl_t;

  typedef struct packed {
    flit_ctrl_t control;
  } flit_t;

  typedef struct packed {
    logic                   credit_valid;
    vc_index_t              credit;
    logic [FC_RET_BITS-1:0] credit_cnt;
  } chan_cntrl_multi_t;

  function automatic vc_index_t oh2bin(input logic [FC_NUM_VCS-1:0] oh);
    vc_index_t idx;
    idx = '0;
    for (int i = 0; i < FC_NUM_VCS; i++)
      if (oh[i]) idx = idx | vc_index_t'(i);
    return idx;
  endfunction

endpackage

// File: rtl/nl_fc_credit_counter.sv
// One VC's saturating credit counter with registered blocked/empty flags.
// With NL_FC_CREDIT_CHECK_EN defined, a sticky over/underflow flag is kept.
module nl_fc_credit_counter
  import nl_fc_pkg::*;
#(
  parameter int init_credits = 4,
  parameter int counter_bits = 3,
  parameter int ret_bits     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ret_bits-1:0]     inc,
  input  logic                    dec,
  input  logic                    reinit,
  output logic [counter_bits-1:0] credits,
  output logic                    status,
  output logic                    empty,
  output logic                    err
);

  localparam int SUM_BITS = counter_bits + ret_bits + 1;
  localparam logic [counter_bits-1:0] INIT = counter_bits'(init_credits);

  logic [counter_bits-1:0] count_q, count_d;
  logic [SUM_BITS-1:0]     sum_inc, sum_net;
  logic                    underflow, overflow;
  logic                    status_q, empty_q;

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    sum_inc   = SUM_BITS'(count_q) + SUM_BITS'(inc);
    underflow = dec && (sum_inc == '0);
    sum_net   = sum_inc - SUM_BITS'(dec);
    overflow  = !underflow && (sum_net > SUM_BITS'(init_credits));
    if (reinit)         count_d = INIT;
    else if (underflow) count_d = '0;
    else if (overflow)  count_d = INIT;
    else                count_d = sum_net[counter_bits-1:0];
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= INIT;
      status_q <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      count_q  <= count_d;
      status_q <= (count_d == '0);
      empty_q  <= (count_d == INIT);
    end
  end

  assign credits = count_q;
  assign status  = status_q;
  assign empty   = empty_q;

`ifdef NL_FC_CREDIT_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (reinit) begin
      err_q <= 1'b0;
    end else if (underflow || overflow) begin
      err_q <= 1'b1;
      $error("credit %s on VC counter (count=%0d inc=%0d dec=%0b)",
             underflow ? "underflow" : "overflow", count_q, inc, dec);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/nl_vc_credit_fc_out.sv
// Output-port credit flow control: one credit counter per virtual channel.
// Define NL_FC_CREDIT_CHECK_EN to enable sticky credit-error flags.
module nl_vc_credit_fc_out
  import nl_fc_pkg::*;
#(
  parameter int num_vcs        = FC_NUM_VCS,
  parameter int init_credits   = 4,
  parameter int max_credit_ret = FC_MAX_CREDIT_RET,
  parameter int counter_bits   = clogb2(init_credits + 1),
  parameter int ret_bits       = clogb2(max_credit_ret + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  flit_t                           flit,
  input  logic                            flit_valid,
  input  chan_cntrl_multi_t               channel_cntrl_in,
  input  logic [num_vcs-1:0]              credit_reinit,
  output logic [num_vcs-1:0]              vc_status,
  output logic [num_vcs-1:0]              vc_empty,
  output logic [num_vcs*counter_bits-1:0] vc_credits,
  output logic [num_vcs-1:0]              credit_err
);

  // flit.control.vc_id is sized by FC_NUM_VCS; num_vcs must not exceed it.
  for (genvar v = 0; v < num_vcs; v++) begin : g_vc
    logic [ret_bits-1:0] inc;
    logic                dec;

    // Indices at or beyond num_vcs never match and are therefore dropped.
    assign inc = (channel_cntrl_in.credit_valid && channel_cntrl_in.credit == vc_index_t'(v))
               ? ret_bits'(channel_cntrl_in.credit_cnt) : '0;
    assign dec = flit_valid && flit.control.vc_id[v];

    nl_fc_credit_counter #(
      .init_credits (init_credits),
      .counter_bits (counter_bits),
      .ret_bits     (ret_bits)
    ) u_counter (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc),
      .dec     (dec),
      .reinit  (credit_reinit[v]),
      .credits (vc_credits[v*counter_bits +: counter_bits]),
      .status  (vc_status[v]),
      .empty   (vc_empty[v]),
      .err     (credit_err[v])
    );
  end

endmodule

// File: tb/tb_nl_vc_credit_fc_out.sv
// Directed bench for nl_vc_credit_fc_out (num_vcs=2, init_credits=4, max_credit_ret=2).
module tb_nl_vc_credit_fc_out;
  import nl_fc_pkg::*;

  localparam int NV = 2;
  localparam int CB = 3;
`ifdef NL_FC_CREDIT_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  flit_t             flit;
  logic              flit_valid;
  chan_cntrl_multi_t cc;
  logic [NV-1:0]     credit_reinit;
  logic [NV-1:0]     vc_status, vc_empty, credit_err;
  logic [NV*CB-1:0]  vc_credits;

  int n_checks = 0;
  int n_fail   = 0;

  nl_vc_credit_fc_out #(
    .num_vcs(NV), .init_credits(4), .max_credit_ret(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flit             (flit),
    .flit_valid       (flit_valid),
    .channel_cntrl_in (cc),
    .credit_reinit    (credit_reinit),
    .vc_status        (vc_status),
    .vc_empty         (vc_empty),
    .vc_credits       (vc_credits),
    .credit_err       (credit_err)
  );

  always #5 clk = ~clk;

  function automatic logic [CB-1:0] cr(input int v);
    return vc_credits[v*CB +: CB];
  endfunction

  // One clock with the given inputs, then idle inputs; outputs sampled 1 ns after the edge.
  task automatic cycle(input logic [NV-1:0] fvc, input logic cv, input vc_index_t ci,
                       input logic [1:0] cnt, input logic [NV-1:0] reinit);
    flit.control.vc_id = fvc;
    flit_valid         = |fvc;
    cc.credit_valid    = cv;
    cc.credit          = ci;
    cc.credit_cnt      = cnt;
    credit_reinit      = reinit;
    @(posedge clk);
    #1;
    flit.control.vc_id = '0;
    flit_valid         = 1'b0;
    cc                 = '0;
    credit_reinit      = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flit = '0; flit_valid = 1'b0; cc = '0; credit_reinit = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (vc_credits !== {3'd4, 3'd4}) begin
      n_fail++; $display("FAIL reset_credits: got %h want %h", vc_credits, {3'd4, 3'd4});
    end
    n_checks++;
    if ({vc_status, vc_empty, credit_err} !== 6'b00_11_00) begin
      n_fail++; $display("FAIL reset_flags: got %b want %b", {vc_status, vc_empty, credit_err}, 6'b00_11_00);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      cycle(2'b01, 1'b0, '0, 2'd0, 2'b00);
      n_checks++;
      if (cr(0) !== CB'(3 - i)) begin
        n_fail++; $display("FAIL b2b_cred0[%0d]: got %0d want %0d", i, cr(0), 3 - i);
      end
    end
    n_checks++;
    if ({vc_status[0], vc_empty[0]} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_vc0_flags: got %b want 10", {vc_status[0], vc_empty[0]});
    end
    n_checks++;
    if ({cr(1), vc_status[1], vc_empty[1]} !== {3'd4, 2'b01}) begin
      n_fail++; $display("FAIL b2b_vc1_idle: got %b want %b", {cr(1), vc_status[1], vc_empty[1]}, {3'd4, 2'b01});
    end
  endtask

  task automatic test_multi_credit();
    cycle(2'b00, 1'b1, 3'd0, 2'd2, 2'b00);
    n_checks++;
    if ({cr(0), vc_status[0]} !== {3'd2, 1'b0}) begin
      n_fail++; $display("FAIL ret2_first: got %b want %b", {cr(0), vc_status[0]}, {3'd2, 1'b0});
    end
    cycle(2'b00, 1'b1, 3'd0, 2'd2, 2'b00);
    n_checks++;
    if ({cr(0), vc_empty[0]} !== {3'd4, 1'b1}) begin
      n_fail++; $display("FAIL ret2_second: got %b want %b", {cr(0), vc_empty[0]}, {3'd4, 1'b1});
    end
  endtask

  task automatic test_simultaneous();
    repeat (3) cycle(2'b10, 1'b0, '0, 2'd0, 2'b00);
    n_checks++;
    if (cr(1) !== 3'd1) begin
      n_fail++; $display("FAIL simul_setup: got %0d want 1", cr(1));
    end
    cycle(2'b10, 1'b1, 3'd1, 2'd1, 2'b00);
    n_checks++;
    if ({cr(1), vc_status[1], credit_err[1]} !== {3'd1, 2'b00}) begin
      n_fail++; $display("FAIL simul_net0: got %b want %b", {cr(1), vc_status[1], credit_err[1]}, {3'd1, 2'b00});
    end
  endtask

  task automatic test_overflow_reinit();
    cycle(2'b00, 1'b1, 3'd0, 2'd2, 2'b00);
    n_checks++;
    if ({cr(0), credit_err[0]} !== {3'd4, ERR_ON}) begin
      n_fail++; $display("FAIL ovf_sat: got %b want %b", {cr(0), credit_err[0]}, {3'd4, ERR_ON});
    end
    cycle(2'b00, 1'b0, '0, 2'd0, 2'b01);
    n_checks++;
    if ({cr(0), vc_empty[0], credit_err[0]} !== {3'd4, 2'b10}) begin
      n_fail++; $display("FAIL ovf_reinit: got %b want %b", {cr(0), vc_empty[0], credit_err[0]}, {3'd4, 2'b10});
    end
  endtask

  task automatic test_ignored_credits();
    cycle(2'b00, 1'b1, 3'd5, 2'd2, 2'b00);
    n_checks++;
    if (vc_credits !== {3'd1, 3'd4}) begin
      n_fail++; $display("FAIL bad_index: got %h want %h", vc_credits, {3'd1, 3'd4});
    end
    cycle(2'b00, 1'b1, 3'd1, 2'd0, 2'b00);
    n_checks++;
    if ({cr(1), credit_err} !== {3'd1, 2'b00}) begin
      n_fail++; $display("FAIL zero_cnt: got %b want %b", {cr(1), credit_err}, {3'd1, 2'b00});
    end
  endtask

  task automatic test_underflow_async_reset();
    cycle(2'b10, 1'b0, '0, 2'd0, 2'b00);
    n_checks++;
    if ({cr(1), vc_status[1]} !== {3'd0, 1'b1}) begin
      n_fail++; $display("FAIL unf_setup: got %b want %b", {cr(1), vc_status[1]}, {3'd0, 1'b1});
    end
    cycle(2'b10, 1'b0, '0, 2'd0, 2'b00);
    n_checks++;
    if ({cr(1), vc_status[1], credit_err[1]} !== {3'd0, 1'b1, ERR_ON}) begin
      n_fail++; $display("FAIL unf_stay0: got %b want %b", {cr(1), vc_status[1], credit_err[1]}, {3'd0, 1'b1, ERR_ON});
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({vc_credits, vc_status, vc_empty, credit_err} !== {3'd4, 3'd4, 6'b00_11_00}) begin
      n_fail++; $display("FAIL async_rst: got %b want %b", {vc_credits, vc_status, vc_empty, credit_err},
                         {3'd4, 3'd4, 6'b00_11_00});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reinit_precedence();
    repeat (3) cycle(2'b01, 1'b0, '0, 2'd0, 2'b00);
    n_checks++;
    if (cr(0) !== 3'd1) begin
      n_fail++; $display("FAIL prec_setup: got %0d want 1", cr(0));
    end
    cycle(2'b01, 1'b1, 3'd0, 2'd2, 2'b01);
    n_checks++;
    if ({cr(0), vc_empty[0], vc_status[0]} !== {3'd4, 2'b10}) begin
      n_fail++; $display("FAIL prec_reinit: got %b want %b", {cr(0), vc_empty[0], vc_status[0]}, {3'd4, 2'b10});
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_multi_credit();
    test_simultaneous();
    test_overflow_reinit();
    test_ignored_credits();
    test_underflow_async_reset();
    test_reinit_precedence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
